// File: rtl/sa_acc_pkg.sv
// Shared types and default widths for the systolic-array accumulator lane.
package sa_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } acc_state_t;

    localparam int PSUM_WIDTH_DEF    = 20;
    localparam int ACC_WIDTH_DEF     = 32;
    localparam int DATA_WIDTH_DEF    = 8;
    localparam int ADDRESS_WIDTH_DEF = 10;
    localparam int DEPTH_DEF         = 64;
    localparam int SHIFT_WIDTH       = 5;

endpackage

// File: rtl/sa_acc_requant.sv
// Combinational requantizer: arithmetic right shift, optional round-half-up
// (build macro SA_ACC_ROUND_EN), then saturation to DATA_WIDTH.
module sa_acc_requant
    import sa_acc_pkg::*;
#(
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [ACC_WIDTH-1:0]   acc_i,
    input  logic [SHIFT_WIDTH-1:0] shift_i,
    output logic [DATA_WIDTH-1:0]  result_o
);

    // One guard bit so the rounding bias can never wrap the accumulator value.
    localparam logic signed [ACC_WIDTH:0] MAX_V =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] MIN_V =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0] ONE_V = {{ACC_WIDTH{1'b0}}, 1'b1};

    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] biased;
    logic signed [ACC_WIDTH:0] shifted;

    always_comb begin
        ext = {acc_i[ACC_WIDTH-1], acc_i};
`ifdef SA_ACC_ROUND_EN
        if (shift_i != '0) begin
            biased = ext + (ONE_V <<< (shift_i - 5'd1));
        end else begin
            biased = ext;
        end
`else
        biased = ext;
`endif
        shifted = biased >>> shift_i;
        if (shifted > MAX_V) begin
            result_o = MAX_V[DATA_WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            result_o = MIN_V[DATA_WIDTH-1:0];
        end else begin
            result_o = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/sa_accumulator.sv
// Accumulator lane: sums K passes of partial sums into a flop buffer, then
// drains requantized results (rounding selected by SA_ACC_ROUND_EN).
//
// state | meaning
// IDLE  | waiting for cfg_start_i; drain pipeline may still be emptying
// ACCUM | accepting partial sums, pass by pass
// DRAIN | walking the buffer, one element per cycle into the output pipe
module sa_accumulator
    import sa_acc_pkg::*;
#(
    parameter int PSUM_WIDTH    = PSUM_WIDTH_DEF,
    parameter int ACC_WIDTH     = ACC_WIDTH_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int DEPTH         = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_start_i,
    input  logic [$clog2(DEPTH)-1:0]   cfg_len_m1_i,
    input  logic [7:0]                 cfg_passes_m1_i,
    input  logic [SHIFT_WIDTH-1:0]     cfg_shift_i,
    input  logic [ADDRESS_WIDTH-1:0]   cfg_base_addr_i,
    input  logic                       psum_valid_i,
    input  logic [PSUM_WIDTH-1:0]      psum_i,
    output logic                       acc_valid_o,
    output logic                       acc_last_o,
    output logic [DATA_WIDTH-1:0]      acc_result_o,
    output logic [ADDRESS_WIDTH-1:0]   acc_result_address_o,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int IDX_W = $clog2(DEPTH);

    acc_state_t               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [7:0]               pass_q, pass_d;
    logic [IDX_W-1:0]         len_q, len_d;
    logic [7:0]               passes_q, passes_d;
    logic [SHIFT_WIDTH-1:0]   shift_q, shift_d;
    logic [ADDRESS_WIDTH-1:0] base_q, base_d;
    logic                     err_q, err_d;
    logic                     busy_q, busy_d;

    logic                     rd_valid_q, rd_valid_d;
    logic                     rd_last_q, rd_last_d;
    logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;

    logic                     acc_valid_q, acc_valid_d;
    logic                     acc_last_q, acc_last_d;
    logic [DATA_WIDTH-1:0]    acc_result_q, acc_result_d;
    logic [ADDRESS_WIDTH-1:0] acc_addr_q, acc_addr_d;

    logic [ACC_WIDTH-1:0]     buf_q [DEPTH];
    logic                     buf_we;
    logic [ACC_WIDTH-1:0]     buf_wdata;
    logic [ACC_WIDTH-1:0]     psum_ext;
    logic [DATA_WIDTH-1:0]    req_result;

    assign psum_ext = {{(ACC_WIDTH-PSUM_WIDTH){psum_i[PSUM_WIDTH-1]}}, psum_i};

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        len_d     = len_q;
        passes_d  = passes_q;
        shift_d   = shift_q;
        base_d    = base_q;
        err_d     = err_q;
        buf_we    = 1'b0;
        buf_wdata = psum_ext;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_idx_d   = rd_idx_q;

        case (state_q)
            IDLE: begin
                // Start is refused until the drain pipeline has emptied.
                if (cfg_start_i && !busy_q) begin
                    len_d    = cfg_len_m1_i;
                    passes_d = cfg_passes_m1_i;
                    shift_d  = cfg_shift_i;
                    base_d   = cfg_base_addr_i;
                    idx_d    = '0;
                    pass_d   = '0;
                    state_d  = ACCUM;
                end else if (cfg_start_i) begin
                    err_d = 1'b1;
                end
                if (psum_valid_i) begin
                    err_d = 1'b1;
                end
            end
            ACCUM: begin
                if (cfg_start_i) begin
                    err_d = 1'b1;
                end
                if (psum_valid_i) begin
                    buf_we    = 1'b1;
                    buf_wdata = (pass_q == 8'd0) ? psum_ext : buf_q[idx_q] + psum_ext;
                    if (idx_q == len_q) begin
                        idx_d  = '0;
                        pass_d = pass_q + 8'd1;
                        if (pass_q == passes_q) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (cfg_start_i || psum_valid_i) begin
                    err_d = 1'b1;
                end
                rd_valid_d = 1'b1;
                rd_idx_d   = idx_q;
                rd_last_d  = (idx_q == len_q);
                if (idx_q == len_q) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sa_acc_requant #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_requant (
        .acc_i    (buf_q[rd_idx_q]),
        .shift_i  (shift_q),
        .result_o (req_result)
    );

    always_comb begin
        acc_valid_d  = rd_valid_q;
        acc_last_d   = rd_last_q;
        acc_result_d = rd_valid_q ? req_result : '0;
        acc_addr_d   = rd_valid_q ? base_q + ADDRESS_WIDTH'(rd_idx_q) : '0;
        // Busy stays up until the cycle after the last element leaves.
        busy_d       = (state_d != IDLE) || rd_valid_d || acc_valid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            pass_q       <= '0;
            len_q        <= '0;
            passes_q     <= '0;
            shift_q      <= '0;
            base_q       <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_idx_q     <= '0;
            acc_valid_q  <= 1'b0;
            acc_last_q   <= 1'b0;
            acc_result_q <= '0;
            acc_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pass_q       <= pass_d;
            len_q        <= len_d;
            passes_q     <= passes_d;
            shift_q      <= shift_d;
            base_q       <= base_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            rd_idx_q     <= rd_idx_d;
            acc_valid_q  <= acc_valid_d;
            acc_last_q   <= acc_last_d;
            acc_result_q <= acc_result_d;
            acc_addr_q   <= acc_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[idx_q] <= buf_wdata;
        end
    end

    assign acc_valid_o          = acc_valid_q;
    assign acc_last_o           = acc_last_q;
    assign acc_result_o         = acc_result_q;
    assign acc_result_address_o = acc_addr_q;
    assign busy_o               = busy_q;
    assign err_o                = err_q;

endmodule

// File: tb/tb_sa_accumulator.sv
// Randomized self-checking bench for sa_accumulator against an arithmetic
// reference of the accumulate / shift / saturate rules.
module tb_sa_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_start_i = 1'b0;
    logic [5:0]  cfg_len_m1_i = '0;
    logic [7:0]  cfg_passes_m1_i = '0;
    logic [4:0]  cfg_shift_i = '0;
    logic [9:0]  cfg_base_addr_i = '0;
    logic        psum_valid_i = 1'b0;
    logic [19:0] psum_i = '0;
    logic        acc_valid_o;
    logic        acc_last_o;
    logic [7:0]  acc_result_o;
    logic [9:0]  acc_result_address_o;
    logic        busy_o;
    logic        err_o;

    sa_accumulator dut (
        .clk                  (clk),
        .rst                  (rst),
        .cfg_start_i          (cfg_start_i),
        .cfg_len_m1_i         (cfg_len_m1_i),
        .cfg_passes_m1_i      (cfg_passes_m1_i),
        .cfg_shift_i          (cfg_shift_i),
        .cfg_base_addr_i      (cfg_base_addr_i),
        .psum_valid_i         (psum_valid_i),
        .psum_i               (psum_i),
        .acc_valid_o          (acc_valid_o),
        .acc_last_o           (acc_last_o),
        .acc_result_o         (acc_result_o),
        .acc_result_address_o (acc_result_address_o),
        .busy_o               (busy_o),
        .err_o                (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    int q_res[$];
    int q_addr[$];
    bit q_last[$];
    int first_cyc = -1;
    int last_acc_cyc = 0;
    int stim_q[$];

    always @(negedge clk) begin
        if (rst && acc_valid_o) begin
            q_res.push_back(int'($signed(acc_result_o)));
            q_addr.push_back(int'(acc_result_address_o));
            q_last.push_back(acc_last_o);
            if (first_cyc < 0) first_cyc = cyc;
        end
    end

    function automatic int model_q(input int sum, input int shift);
        longint v;
        v = longint'(sum);
`ifdef SA_ACC_ROUND_EN
        if (shift > 0) v = v + (longint'(1) << (shift - 1));
`endif
        v = v >>> shift;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return int'(v);
    endfunction

    function automatic int rand_psum();
        return int'($urandom_range(0, 1048575)) - 524288;
    endfunction

    task automatic fill_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(rand_psum());
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cfg_start_i = 1'b0;
        psum_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic start_tile(input int len_m1, input int passes_m1, input int shift, input int base);
        q_res.delete();
        q_addr.delete();
        q_last.delete();
        first_cyc = -1;
        @(posedge clk); #1;
        cfg_start_i = 1'b1;
        cfg_len_m1_i = 6'(len_m1);
        cfg_passes_m1_i = 8'(passes_m1);
        cfg_shift_i = 5'(shift);
        cfg_base_addr_i = 10'(base);
        @(posedge clk); #1;
        cfg_start_i = 1'b0;
        cfg_len_m1_i = 6'($urandom);
        cfg_passes_m1_i = 8'($urandom);
        cfg_shift_i = 5'($urandom);
        cfg_base_addr_i = 10'($urandom);
    endtask

    task automatic run_tile(input int len_m1, input int passes_m1, input int shift, input int base,
                            input int max_gap, input bit mid_start, input bit drain_psum);
        int sums[64];
        int k;
        int v;
        int n;
        int wait_n;
        n = len_m1 + 1;
        k = 0;
        wait_n = 0;
        start_tile(len_m1, passes_m1, shift, base);
        for (int p = 0; p <= passes_m1; p++) begin
            for (int i = 0; i < n; i++) begin
                v = stim_q[k];
                k++;
                if (p == 0) sums[i] = v;
                else sums[i] = sums[i] + v;
                repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
                psum_valid_i = 1'b1;
                psum_i = 20'(v);
                if (mid_start && k == 2) cfg_start_i = 1'b1;
                @(posedge clk); #1;
                psum_valid_i = 1'b0;
                cfg_start_i = 1'b0;
                psum_i = 20'($urandom);
                last_acc_cyc = cyc;
            end
        end
        if (drain_psum) begin
            psum_valid_i = 1'b1;
            @(posedge clk); #1;
            psum_valid_i = 1'b0;
        end
        while (busy_o && wait_n < 400) begin
            @(posedge clk); #1;
            wait_n++;
        end
        chk("drain_done", longint'(busy_o), 0);
        chk("count", q_res.size(), n);
        for (int i = 0; i < n && i < q_res.size(); i++) begin
            chk($sformatf("res[%0d]", i), q_res[i], model_q(sums[i], shift));
            chk($sformatf("addr[%0d]", i), q_addr[i], (base + i) % 1024);
            chk($sformatf("last[%0d]", i), longint'(q_last[i]), longint'(i == len_m1));
        end
        chk("latency", first_cyc - last_acc_cyc, 2);
        chk("err", longint'(err_o), longint'(mid_start | drain_psum));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int len;
        int passes;
        int wait_n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", longint'(acc_valid_o), 0);
        chk("rst_last", longint'(acc_last_o), 0);
        chk("rst_result", longint'(acc_result_o), 0);
        chk("rst_addr", longint'(acc_result_address_o), 0);
        chk("rst_busy", longint'(busy_o), 0);
        chk("rst_err", longint'(err_o), 0);
        rst = 1'b1;

        @(posedge clk); #1;
        psum_valid_i = 1'b1;
        @(posedge clk); #1;
        psum_valid_i = 1'b0;
        chk("idle_psum_err", longint'(err_o), 1);
        chk("idle_psum_busy", longint'(busy_o), 0);

        do_reset();
        stim_q = '{1, 2, 3, 4};
        run_tile(3, 0, 0, 100, 0, 1'b0, 1'b0);
        chk("single_res3", q_res[3], 4);
        chk("single_addr0", q_addr[0], 100);

        do_reset();
        stim_q = '{10, -6, 10, -6, 10, -6};
        run_tile(1, 2, 1, 0, 0, 1'b0, 1'b0);
        chk("three_pass_res1", q_res[1], -9);

        do_reset();
        stim_q = '{5000, -5000};
        run_tile(1, 0, 4, 5, 1, 1'b0, 1'b0);
        chk("sat_hi", q_res[0], 127);
        chk("sat_lo", q_res[1], -128);

        do_reset();
        stim_q = '{7};
        run_tile(0, 0, 1, 7, 0, 1'b0, 1'b0);

        do_reset();
        fill_random(8);
        run_tile(3, 1, 2, 200, 1, 1'b1, 1'b0);

        do_reset();
        fill_random(3);
        run_tile(2, 0, 0, 300, 0, 1'b0, 1'b1);

        do_reset();
        fill_random(4);
        run_tile(3, 0, 3, 1022, 3, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            len = ($urandom_range(0, 3) == 0) ? 63 : int'($urandom_range(0, 15));
            passes = int'($urandom_range(0, 3));
            do_reset();
            fill_random((len + 1) * (passes + 1));
            run_tile(len, passes, int'($urandom_range(0, 12)), int'($urandom_range(0, 1023)),
                     int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        do_reset();
        start_tile(5, 0, 0, 50);
        for (int i = 0; i < 6; i++) begin
            psum_valid_i = 1'b1;
            psum_i = 20'(rand_psum());
            @(posedge clk); #1;
        end
        psum_valid_i = 1'b0;
        wait_n = 0;
        while (q_res.size() < 2 && wait_n < 100) begin
            @(negedge clk); #2;
            wait_n++;
        end
        chk("mid_drain_reached", q_res.size() >= 2, 1);
        rst = 1'b0;
        #1;
        chk("abort_valid", longint'(acc_valid_o), 0);
        chk("abort_last", longint'(acc_last_o), 0);
        chk("abort_result", longint'(acc_result_o), 0);
        chk("abort_addr", longint'(acc_result_address_o), 0);
        chk("abort_busy", longint'(busy_o), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        fill_random(12);
        run_tile(5, 1, 1, 60, 1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
